// File: rtl/matmul_pkg.sv
// Shared types for the matrix loader: FSM state encoding and element width.
package matmul_pkg;
  localparam int ELEM_W = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FIRE   = 2'd2,
    DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/matrix_loader.sv
// Streams N*N bytes into A, then N*N into B (row-major), then pulses trigmult and done.
// Optional MATRIX_LOADER_ABORT_EN adds a synchronous abort input that restarts loading.
module matrix_loader
  import matmul_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [ELEM_W-1:0]          in_data,
`ifdef MATRIX_LOADER_ABORT_EN
  input  logic                       abort,
`endif
  output logic                       in_ready,
  output logic [N*N*ELEM_W-1:0]      A,
  output logic [N*N*ELEM_W-1:0]      B,
  output logic                       trigmult,
  output logic                       done
);
  localparam int NN = N * N;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NN*ELEM_W-1:0]    a_q, a_d, b_q, b_d;
  logic                    xfer, last, abort_w;

`ifdef MATRIX_LOADER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign A = a_q;
  assign B = b_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    // Handshake and strobes depend on state only, never on in_valid.
    in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    trigmult = (state_q == FIRE);
    done     = (state_q == DONE);
    xfer     = in_valid && in_ready;
    last     = (cnt_q == CW'(NN - 1));

    unique case (state_q)
      LOAD_A, LOAD_B: begin
        if (abort_w) begin
          // Abort drops the same-cycle byte and leaves A/B contents alone.
          state_d = LOAD_A;
          cnt_d   = '0;
        end else if (xfer) begin
          if (state_q == LOAD_A) a_d[int'(cnt_q)*ELEM_W +: ELEM_W] = in_data;
          else                   b_d[int'(cnt_q)*ELEM_W +: ELEM_W] = in_data;
          cnt_d = last ? '0 : cnt_q + CW'(1);
          if (last) state_d = (state_q == LOAD_A) ? LOAD_B : FIRE;
        end
      end
      FIRE:    state_d = DONE;
      DONE:    state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader against a sequence-position model.
module tb_matrix_loader;
  localparam int N  = 2;
  localparam int NN = N * N;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data = 8'd0;
  logic            abort_s = 1'b0;
  logic            in_ready, trigmult, done;
  logic [NN*8-1:0] A, B;

  always #5 clk = ~clk;

  matrix_loader #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef MATRIX_LOADER_ABORT_EN
    .abort    (abort_s),
`endif
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .trigmult (trigmult),
    .done     (done)
  );

  int n_chk = 0;
  int n_pass = 0;
  // Model: pos 0..NN-1 loading A, NN..2NN-1 loading B, 2NN fire, 2NN+1 done.
  int pos = 0;
  logic [7:0] ma [NN];
  logic [7:0] mb [NN];

  function automatic logic [NN*8-1:0] flat(input logic [7:0] m [NN]);
    logic [NN*8-1:0] r;
    r = '0;
    for (int k = 0; k < NN; k++) r[k*8 +: 8] = m[k];
    return r;
  endfunction

  function automatic int res_lane(input logic [NN*8-1:0] a, input logic [NN*8-1:0] b, input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(a[(i*N+k)*8 +: 8]) * int'(b[(k*N+j)*8 +: 8]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    pos = 0;
    for (int k = 0; k < NN; k++) begin ma[k] = 8'd0; mb[k] = 8'd0; end
  endtask

  task automatic step(input logic v, input logic [7:0] d, output bit acc);
    bit ab;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    #1;
    chk("in_ready", in_ready, pos < 2*NN);
    chk("trigmult", trigmult, pos == 2*NN);
    chk("done",     done,     pos == 2*NN+1);
    if (pos == 2*NN) begin
      chk("A_at_fire", A, flat(ma));
      chk("B_at_fire", B, flat(mb));
    end
    ab = 1'b0;
`ifdef MATRIX_LOADER_ABORT_EN
    ab = abort_s;
`endif
    @(posedge clk);
    acc = 1'b0;
    if (pos < 2*NN) begin
      if (ab) pos = 0;
      else if (v) begin
        acc = 1'b1;
        if (pos < NN) ma[pos] = d; else mb[pos-NN] = d;
        pos++;
      end
    end else begin
      pos = (pos == 2*NN+1) ? 0 : pos + 1;
    end
    #1;
    chk("A", A, flat(ma));
    chk("B", B, flat(mb));
  endtask

  // gaps: 0 back-to-back, 1 alternate valid, 2 random valid; source holds unaccepted bytes
  task automatic feed(input logic [7:0] q [$], input int gaps);
    int  guard;
    bit  tog, acc;
    logic v;
    guard = 0;
    tog   = 1'b1;
    while (q.size() > 0 && guard < 2000) begin
      v = (gaps == 0) ? 1'b1 : (gaps == 1) ? tog : ($urandom_range(0, 9) < 7);
      step(v, q[0], acc);
      if (acc) void'(q.pop_front());
      tog = ~tog;
      guard++;
    end
    chk("feed_bound_left", q.size(), 0);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(1'b0, 8'd0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_trig", trigmult, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_A", A, 0);
    rst = 1'b0;
    model_clear();
    #1;
    chk("post_rst_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] q [$];
    bit acc;
    model_clear();

    do_reset();

    // Directed stream with product check at done.
    q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd8, 8'd7, 8'd6};
    feed(q, 0);
    chk("dir_pos_fire", pos, 2*NN);
    chk("dir_A", A, 32'h04030201);
    chk("dir_B", B, 32'h06070809);
    step(1'b0, 8'd0, acc);
    chk("res00", res_lane(A, B, 0, 0), 23);
    chk("res01", res_lane(A, B, 0, 1), 20);
    chk("res10", res_lane(A, B, 1, 0), 55);
    chk("res11", res_lane(A, B, 1, 1), 48);
    step(1'b0, 8'd0, acc);

    // Same stream with bubbles.
    feed(q, 1);
    chk("bub_A", A, 32'h04030201);
    chk("bub_B", B, 32'h06070809);
    idle(2);

    // Valid held high across FIRE/DONE into the next pair.
    q.delete();
    for (int k = 0; k < 4*NN; k++) q.push_back(8'($urandom));
    feed(q, 0);
    idle(2);

    // Reset mid-pair, then a fresh pair.
    q.delete();
    for (int k = 0; k < 5; k++) q.push_back(8'($urandom));
    feed(q, 0);
    do_reset();
    q.delete();
    for (int k = 0; k < 2*NN; k++) q.push_back(8'($urandom));
    feed(q, 2);
    idle(3);

    // Random pairs with random gaps.
    for (int r = 0; r < 4; r++) begin
      q.delete();
      for (int k = 0; k < 2*NN; k++) q.push_back(8'($urandom));
      feed(q, 2);
      idle($urandom_range(0, 3));
    end
    idle(3);

`ifdef MATRIX_LOADER_ABORT_EN
    q.delete();
    for (int k = 0; k < NN+2; k++) q.push_back(8'($urandom));
    feed(q, 0);
    abort_s = 1'b1;
    step(1'b1, 8'hAA, acc);
    abort_s = 1'b0;
    chk("abort_pos", pos, 0);
    step(1'b1, 8'h5C, acc);
    chk("abort_A0", A[7:0], 8'h5C);
    idle(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter N, default 2, matrix dimension (N x N); legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  byte on in_data is offered.
REQ-005 in_data  input  8  unsigned matrix element byte.
REQ-006 in_ready  output  1  loader can accept a byte this cycle.
REQ-007 A  output  N*N*8  flat matrix A; element (i,j) at bits [(i*N+j)*8 +: 8].
REQ-008 B  output  N*N*8  flat matrix B; same packing as A.
REQ-009 trigmult  output  1  one-cycle start strobe to the downstream multiplier.
REQ-010 done  output  1  one-cycle strobe: the downstream Res is valid this cycle.

Function
REQ-011 A byte transfer occurs on any rising edge where in_valid and in_ready are both 1; no other edge changes A or B.
REQ-012 FSM states are LOAD_A, LOAD_B, FIRE, DONE, in that order, returning from DONE to LOAD_A.
REQ-013 in_ready is 1 only in LOAD_A and LOAD_B, and is decoded from state alone, with no dependence on in_valid.
REQ-014 An element counter of width max(1,$clog2(N*N)) runs from 0 to N*N-1 and selects the byte lane written; element order is row-major (index i*N+j).
REQ-015 LOAD_A: each transfer writes A lane idx; on the transfer at idx = N*N-1, the counter clears and the FSM goes to LOAD_B.
REQ-016 LOAD_B: same as LOAD_A but writes B; the last transfer moves the FSM to FIRE.
REQ-017 FIRE lasts exactly one cycle with trigmult = 1; A and B are stable and fully loaded throughout that cycle.
REQ-018 DONE lasts exactly one cycle with done = 1 (the downstream result is registered on the FIRE edge); the next state is LOAD_A.
REQ-019 trigmult and done are never 1 in the same cycle, and each is 1 for exactly one cycle per matrix pair.
REQ-020 in_valid is ignored in FIRE and DONE; bytes offered then are not consumed and not dropped by the loader (the source holds them).
REQ-021 Gaps in in_valid stall the counter and state with no loss; back-to-back transfers are accepted at one per cycle.
REQ-022 Latency: the first byte of A to trigmult is at least 2*N*N cycles; the last B transfer edge to trigmult is 1 cycle.
REQ-023 A and B retain their last values after DONE until they are overwritten byte by byte in the next LOAD_A and LOAD_B.

Reset
REQ-024 While rst = 1: state = LOAD_A, counter = 0, A = 0, B = 0, trigmult = 0, done = 0.
REQ-025 After reset, in_ready = 1 (LOAD_A).
REQ-026 Reset asserted in any state aborts the operation immediately, and no trigmult or done is issued for the partial pair.

Configuration
REQ-027 Macro MATRIX_LOADER_ABORT_EN: when defined, the module adds an input abort (1 bit, synchronous) after in_data.
REQ-028 With MATRIX_LOADER_ABORT_EN defined, abort = 1 on an edge in LOAD_A or LOAD_B sets state = LOAD_A and counter = 0, keeps A and B unchanged, and discards any same-cycle transfer.
REQ-029 With MATRIX_LOADER_ABORT_EN defined, abort is ignored in FIRE and DONE.
REQ-030 Without the macro, the abort port does not exist and the behaviour is as specified in REQ-011..REQ-026.

Structure
REQ-031 Shared package matmul_pkg holds the state enum (LOAD_A, LOAD_B, FIRE, DONE) and constant ELEM_W = 8.
REQ-032 There is no sub-module; the counter and FSM are implemented in one module of roughly 120-200 lines.

Verification
REQ-033 N=2, stream 1,2,3,4,9,8,7,6 back-to-back -> A = {8'd4,8'd3,8'd2,8'd1} and B = {8'd6,8'd7,8'd8,8'd9}; trigmult is 1 for one cycle, 1 cycle after the 8th transfer; done follows on the next cycle.
REQ-034 Same stream with the multiplier attached -> at done, Res lanes 0..3 = 23, 20, 55, 48.
REQ-035 N=2, in_valid toggled 1,0,1,0 with bubbles -> identical A and B; trigmult occurs only after 8 accepted transfers; no extra bytes are consumed.
REQ-036 in_valid held at 1 through FIRE and DONE -> in_ready = 0 in those 2 cycles; the next byte lands in A lane 0 in the following LOAD_A.
REQ-037 rst pulsed after 5 transfers -> A = B = 0, state LOAD_A, and no trigmult; a fresh 8-byte stream then completes normally.
REQ-038 MATRIX_LOADER_ABORT_EN defined, abort on the 3rd B byte -> no trigmult, B lanes 0..1 keep their new values, and the next byte writes A lane 0.
